// File: rtl/immediate_decode_pipe.sv
// Decode-stage immediate extractor: opcode-driven format select and sign extension,
// buffered through a two-entry (main + skid) register pair behind valid/ready.
module immediate_decode_pipe #(
  parameter int XLEN = 32,
  parameter bit RV64 = (XLEN == 64)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instruction,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_instruction,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_imm_type
);

  localparam logic [2:0] T_NONE = 3'd0;
  localparam logic [2:0] T_I    = 3'd1;
  localparam logic [2:0] T_S    = 3'd2;
  localparam logic [2:0] T_B    = 3'd3;
  localparam logic [2:0] T_U    = 3'd4;
  localparam logic [2:0] T_J    = 3'd5;

  function automatic logic [2:0] imm_type_f(input logic [6:0] opcode);
    logic [2:0] t;
    case (opcode)
      7'b0000011, 7'b0010011,
      7'b1100111, 7'b1110011: t = T_I;
      7'b0011011:             t = RV64 ? T_I : T_NONE;
      7'b0100011:             t = T_S;
      7'b1100011:             t = T_B;
      7'b0110111, 7'b0010111: t = T_U;
      7'b1101111:             t = T_J;
      default:                t = T_NONE;
    endcase
    return t;
  endfunction

  // Every format is assembled as a 32-bit signed value first, then widened from bit 31.
  function automatic logic [XLEN-1:0] imm_f(input logic [31:0] inst, input logic [2:0] t);
    logic signed [31:0] imm32;
    logic               s;
    s = inst[31];
    case (t)
      T_I:     imm32 = {{20{s}}, inst[31:20]};
      T_S:     imm32 = {{20{s}}, inst[31:25], inst[11:7]};
      T_B:     imm32 = {{19{s}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      T_U:     imm32 = {inst[31:12], 12'b0};
      T_J:     imm32 = {{11{s}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      default: imm32 = '0;
    endcase
    return {{(XLEN - 31){imm32[31]}}, imm32[30:0]};
  endfunction

  logic [2:0]      dec_type;
  logic [XLEN-1:0] dec_imm;
  logic            accept, pop;

  logic            main_vld_q, main_vld_d, skid_vld_q, skid_vld_d;
  logic [31:0]     main_inst_q, main_inst_d, skid_inst_q, skid_inst_d;
  logic [XLEN-1:0] main_imm_q, main_imm_d, skid_imm_q, skid_imm_d;
  logic [2:0]      main_type_q, main_type_d, skid_type_q, skid_type_d;

  assign dec_type = imm_type_f(in_instruction[6:0]);
  assign dec_imm  = imm_f(in_instruction, dec_type);

  assign in_ready = ~skid_vld_q;
  assign accept   = in_valid & in_ready;
  assign pop      = main_vld_q & out_ready;

  always_comb begin
    main_vld_d  = main_vld_q;
    main_inst_d = main_inst_q;
    main_imm_d  = main_imm_q;
    main_type_d = main_type_q;
    skid_vld_d  = skid_vld_q;
    skid_inst_d = skid_inst_q;
    skid_imm_d  = skid_imm_q;
    skid_type_d = skid_type_q;

    if (flush) begin
      main_vld_d = 1'b0;
      skid_vld_d = 1'b0;
    end else if (!main_vld_q) begin
      if (accept) begin
        main_vld_d  = 1'b1;
        main_inst_d = in_instruction;
        main_imm_d  = dec_imm;
        main_type_d = dec_type;
      end
    end else if (!skid_vld_q) begin
      if (accept && pop) begin
        main_inst_d = in_instruction;
        main_imm_d  = dec_imm;
        main_type_d = dec_type;
      end else if (accept) begin
        skid_vld_d  = 1'b1;
        skid_inst_d = in_instruction;
        skid_imm_d  = dec_imm;
        skid_type_d = dec_type;
      end else if (pop) begin
        main_vld_d = 1'b0;
      end
    end else if (pop) begin
      // Full: in_ready is low, so only the skid-to-main shift can happen.
      main_inst_d = skid_inst_q;
      main_imm_d  = skid_imm_q;
      main_type_d = skid_type_q;
      skid_vld_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_vld_q  <= 1'b0;
      main_inst_q <= '0;
      main_imm_q  <= '0;
      main_type_q <= T_NONE;
      skid_vld_q  <= 1'b0;
      skid_inst_q <= '0;
      skid_imm_q  <= '0;
      skid_type_q <= T_NONE;
    end else begin
      main_vld_q  <= main_vld_d;
      main_inst_q <= main_inst_d;
      main_imm_q  <= main_imm_d;
      main_type_q <= main_type_d;
      skid_vld_q  <= skid_vld_d;
      skid_inst_q <= skid_inst_d;
      skid_imm_q  <= skid_imm_d;
      skid_type_q <= skid_type_d;
    end
  end

  assign out_valid       = main_vld_q;
  assign out_instruction = main_inst_q;
  assign out_imm         = main_imm_q;
  assign out_imm_type    = main_type_q;

endmodule
